// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with bounded tenure, producing a registered one-hot select
// for the downstream one-hot mux; the owner keeps the grant while requesting, up to MAX_HOLD cycles.
module rr_onehot_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic                           gnt_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]     gnt_id_o,
    output logic [$clog2(MAX_HOLD+1)-1:0]  tenure_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TEN_W = $clog2(MAX_HOLD + 1);
    localparam logic [NUM_REQ-1:0] ONE    = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    LAST   = ID_W'(NUM_REQ - 1);
    localparam logic [TEN_W-1:0]   MAX_T  = TEN_W'(MAX_HOLD);
    localparam logic [TEN_W-1:0]   TEN_1  = TEN_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_p0, state_nxt;
    logic [NUM_REQ-1:0]   gnt_p0, gnt_nxt;
    logic [ID_W-1:0]      id_p0, id_nxt;
    logic [TEN_W-1:0]     tenure_p0, tenure_nxt;
    logic [ID_W-1:0]      ptr_p0, ptr_nxt;
    logic [ID_W-1:0]      win;
    logic                 do_grant;

    // First set bit of mask searching upward from start, wrapping at NUM_REQ-1.
    function automatic logic [ID_W-1:0] arb(input logic [NUM_REQ-1:0] mask,
                                            input logic [ID_W-1:0]    start);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && mask[idx[ID_W-1:0]]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        win        = arb(req_i, ptr_p0);
        do_grant   = 1'b0;
        state_nxt  = state_p0;
        gnt_nxt    = gnt_p0;
        id_nxt     = id_p0;
        tenure_nxt = tenure_p0;
        ptr_nxt    = ptr_p0;

        case (state_p0)
            IDLE: begin
                if (|req_i) do_grant = 1'b1;
            end
            GRANT: begin
                if (req_i[id_p0] && (tenure_p0 < MAX_T)) begin
                    tenure_nxt = tenure_p0 + TEN_1;
                end else if (|req_i) begin
                    // Release or expiry: the pointer already sits past the owner,
                    // so the owner only wins again when it is the sole requester.
                    do_grant = 1'b1;
                end else begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    id_nxt     = '0;
                    tenure_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (do_grant) begin
            state_nxt  = GRANT;
            gnt_nxt    = ONE << win;
            id_nxt     = win;
            tenure_nxt = TEN_1;
            ptr_nxt    = (win == LAST) ? '0 : win + ID_W'(1);
        end
    end

    // Stage p0: all outputs come straight from these flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0  <= IDLE;
            gnt_p0    <= '0;
            id_p0     <= '0;
            tenure_p0 <= '0;
            ptr_p0    <= '0;
        end else begin
            state_p0  <= state_nxt;
            gnt_p0    <= gnt_nxt;
            id_p0     <= id_nxt;
            tenure_p0 <= tenure_nxt;
            ptr_p0    <= ptr_nxt;
        end
    end

    assign gnt_o       = gnt_p0;
    assign gnt_valid_o = (state_p0 == GRANT);
    assign gnt_id_o    = id_p0;
    assign tenure_o    = tenure_p0;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios plus randomized requests,
// all checked against a behavioural owner/tenure/pointer model.
module tb_rr_onehot_arbiter;

    localparam int N = 4;
    localparam int H = 4;
    localparam int BOUND = (N - 1) * H + 1;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic [2:0]   tenure;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_owner;   // -1 when idle
    int m_ten;
    int m_ptr;
    int wait_cnt[N];

    rr_onehot_arbiter #(.NUM_REQ(N), .MAX_HOLD(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id),
        .tenure_o    (tenure)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_arb(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [N-1:0] r);
        int w;
        if (m_owner >= 0 && r[m_owner] && m_ten < H) begin
            m_ten++;
        end else if (r != 0) begin
            w       = model_arb(r, m_ptr);
            m_owner = w;
            m_ten   = 1;
            m_ptr   = (w + 1) % N;
        end else begin
            m_owner = -1;
            m_ten   = 0;
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ten   = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    task automatic check_outputs(input string tag);
        int exp_gnt;
        exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        chk({tag, "_gnt"},    int'(gnt),       exp_gnt);
        chk({tag, "_valid"},  int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
        chk({tag, "_id"},     int'(gnt_id),    (m_owner < 0) ? 0 : m_owner);
        chk({tag, "_tenure"}, int'(tenure),    m_ten);
        chk({tag, "_onehot0"}, int'($onehot0(gnt)), 1);
        chk({tag, "_vld_or"}, int'(gnt_valid), int'(|gnt));
        if (gnt_valid) chk({tag, "_gnt_id"}, int'(gnt), 1 << gnt_id);
    endtask

    // Drive one request vector across one rising edge, then check.
    task automatic step(input string tag, input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_outputs(tag);
        for (int i = 0; i < N; i++) begin
            if (r[i] && !gnt[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            chk({tag, "_starve"}, int'(wait_cnt[i] <= BOUND), 1);
        end
    endtask

    // Async reset away from the clock edge; outputs must clear immediately.
    task automatic async_reset(input string tag, input logic [N-1:0] r);
        #2;
        req   = r;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, "_imm"});
        @(posedge clk);
        #1;
        check_outputs({tag, "_held"});
        reset = 1'b0;
        req   = '0;
    endtask

    logic [N-1:0] rq;
    int exp_ten_seq[10] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};

    initial begin
        reset = 1'b1;
        req   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        reset = 1'b0;

        // 1. reset mid-sim with all requesting, then release with no requests
        step("pre", 4'b1111);
        step("pre", 4'b1111);
        async_reset("t1", 4'b1111);
        step("t1_idle", 4'b0000);
        step("t1_idle", 4'b0000);
        chk("t1_gnt_zero", int'(gnt), 0);

        // 2. single request then drop
        step("t2", 4'b0100);
        chk("t2_gnt_c", int'(gnt), 4);
        chk("t2_id_c", int'(gnt_id), 2);
        chk("t2_ten_c", int'(tenure), 1);
        step("t2", 4'b0100);
        step("t2", 4'b0100);
        step("t2_drop", 4'b0000);
        chk("t2_drop_c", int'(gnt), 0);

        // 3. full contention from a fresh pointer
        async_reset("t3rst", 4'b0000);
        for (int k = 0; k < 17; k++) begin
            step("t3", 4'b1111);
            chk("t3_own_c", int'(gnt), 1 << ((k / H) % N));
            chk("t3_ten_c", int'(tenure), (k % H) + 1);
        end

        // 4. bubble-free handoff
        async_reset("t4rst", 4'b0000);
        step("t4", 4'b0011);
        chk("t4_own0_c", int'(gnt), 1);
        step("t4_hand", 4'b0010);
        chk("t4_gnt_c", int'(gnt), 2);
        chk("t4_ten_c", int'(tenure), 1);
        chk("t4_vld_c", int'(gnt_valid), 1);

        // 5. expiry with a sole requester
        async_reset("t5rst", 4'b0000);
        for (int k = 0; k < 10; k++) begin
            step("t5", 4'b0001);
            chk("t5_gnt_c", int'(gnt), 1);
            chk("t5_ten_c", int'(tenure), exp_ten_seq[k]);
        end

        // 6. pointer wrap, then reset mid-grant
        step("t6_idle", 4'b0000);
        step("t6", 4'b1000);
        chk("t6_own3_c", int'(gnt), 8);
        step("t6", 4'b1001);
        step("t6_wrap", 4'b0001);
        chk("t6_wrap_c", int'(gnt), 1);
        step("t6", 4'b0001);
        async_reset("t6rst", 4'b0001);
        step("t6_post", 4'b0011);
        chk("t6_post_c", int'(gnt), 1);

        // Randomized: sticky request bits so contention and long holds both occur
        async_reset("rnd_rst", 4'b0000);
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) rq[i] = ~rq[i];
            end
            if ($urandom_range(399) == 0) async_reset("rnd_rst", rq);
            step("rnd", rq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
